// File: rtl/cnn_buffer_pkg.sv
// Shared output-buffer definitions: buffer address width and the drain FSM state type.
package cnn_buffer_pkg;

  localparam int unsigned ADDR_W = 14;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FILL,
    READ,
    FLUSH,
    DONE
  } drain_state_t;

endpackage

// File: rtl/drain_skid_fifo.sv
// Two-entry skid FIFO that absorbs the BRAM read latency between the read strobe and the stream.
module drain_skid_fifo #(
  parameter int unsigned data_size = 16
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 push,
  input  logic [data_size-1:0] push_data,
  input  logic                 pop,
  output logic [1:0]           count,
  output logic [data_size-1:0] head
);

  logic [data_size-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;

  // Push into a full FIFO is only legal together with a pop; the caller guarantees this.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/output_drain.sv
// Streams one finished output feature map out of an output-buffer bank onto a valid/ready stream.
// Optional build macro: DRAIN_RELU_EN clamps negative words to zero as they enter the skid FIFO.
module output_drain
  import cnn_buffer_pkg::*;
#(
  parameter int unsigned dimdata_size = 16,
  parameter int unsigned data_size    = 16
) (
  input  logic                    r_clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [ADDR_W-1:0]       initial_address,
  input  logic [dimdata_size-1:0] output_featuremapsize,
  input  logic                    fill_done,
  output logic [ADDR_W-1:0]       r_address,
  output logic                    read_enable,
  input  logic [data_size-1:0]    r_data,
  output logic [data_size-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    done
);

  localparam int unsigned CNT_W = 2 * dimdata_size;

  drain_state_t         state;
  drain_state_t         state_nxt;
  logic [CNT_W-1:0]     total_q;
  logic [CNT_W-1:0]     issued_q;
  logic [CNT_W-1:0]     sent_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 inflight_q;
  logic [1:0]           fifo_count;
  logic [data_size-1:0] fifo_head;
  logic [data_size-1:0] push_data;
  logic [2:0]           occupancy;
  logic                 issue;
  logic                 pop;
  logic                 abort;
  logic                 start;
  logic                 fifo_clr_n;

  assign abort      = (state != IDLE) && !enable;
  assign start      = (state == IDLE) && enable;
  assign pop        = (fifo_count != 2'd0) && out_ready;
  assign fifo_clr_n = reset && !abort;

  // A read issued now lands one cycle later; leave room for it even if the stream stalls next cycle.
  assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign issue     = (state == READ) && enable && fill_done &&
                     (issued_q < total_q) && (occupancy < 3'd2);

`ifdef DRAIN_RELU_EN
  assign push_data = r_data[data_size-1] ? '0 : r_data;
`else
  assign push_data = r_data;
`endif

  always_ff @(posedge r_clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (enable) state_nxt = WAIT_FILL;
      WAIT_FILL: if (fill_done) state_nxt = (total_q == '0) ? DONE : READ;
      READ:      if (issued_q == total_q) state_nxt = FLUSH;
      FLUSH:     if (pop && ((sent_q + CNT_W'(1)) == total_q)) state_nxt = DONE;
      DONE:      state_nxt = DONE;
      default:   state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
    end
  end

  // Address/count datapath; leaving a busy state wipes it so a restart begins clean.
  always_ff @(posedge r_clk) begin
    if (!reset || abort) begin
      total_q    <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (start) begin
        addr_q   <= initial_address;
        total_q  <= CNT_W'(output_featuremapsize) * CNT_W'(output_featuremapsize);
        issued_q <= '0;
        sent_q   <= '0;
      end else begin
        if (issue) begin
          addr_q   <= addr_q + ADDR_W'(1);
          issued_q <= issued_q + CNT_W'(1);
        end
        if (pop) begin
          sent_q <= sent_q + CNT_W'(1);
        end
      end
    end
  end

  drain_skid_fifo #(
    .data_size(data_size)
  ) u_fifo (
    .clk      (r_clk),
    .clr_n    (fifo_clr_n),
    .push     (inflight_q),
    .push_data(push_data),
    .pop      (pop),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  always_comb begin
    read_enable = 1'b0;
    r_address   = addr_q;
    out_valid   = 1'b0;
    out_data    = fifo_head;
    done        = 1'b0;
    read_enable = issue;
    out_valid   = (fifo_count != 2'd0);
    done        = (state == DONE);
  end

endmodule

// File: tb/tb_output_drain.sv
// Self-checking bench for output_drain: BRAM model, randomized buffer contents, reference stream per drain.
module tb_output_drain;

  localparam int DEPTH = 16384;

  logic        r_clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [13:0] initial_address = '0;
  logic [15:0] output_featuremapsize = '0;
  logic        fill_done = 1'b0;
  logic [13:0] r_address;
  logic        read_enable;
  logic [15:0] r_data = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        done;

  logic [15:0] mem [DEPTH];
  int compared = 0;
  int mismatched = 0;

  output_drain dut (
    .r_clk                (r_clk),
    .reset                (reset),
    .enable               (enable),
    .initial_address      (initial_address),
    .output_featuremapsize(output_featuremapsize),
    .fill_done            (fill_done),
    .r_address            (r_address),
    .read_enable          (read_enable),
    .r_data               (r_data),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .done                 (done)
  );

  always #5 r_clk = ~r_clk;

  // One-cycle-latency BRAM.
  always @(posedge r_clk) begin
    if (read_enable) r_data <= mem[r_address];
  end

  function automatic logic [15:0] ref_word(input logic [15:0] raw);
`ifdef DRAIN_RELU_EN
    return raw[15] ? 16'h0000 : raw;
`else
    return raw;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 ready held high, 1 ready toggling, 2 ready random.
  task automatic run_drain(input string tag, input logic [13:0] base, input logic [15:0] n,
                           input int mode, input int fill_delay);
    logic [15:0] got[$];
    logic [13:0] addrs[$];
    logic [15:0] held;
    logic        held_valid;
    logic        seen_done;
    int total, cyc, first_re, first_ov, first_x, last_x, stall_err, nofill_err, addr_err;
    total = int'(n) * int'(n);
    first_re = -1; first_ov = -1; first_x = -1; last_x = -1;
    stall_err = 0; nofill_err = 0; addr_err = 0;
    held = '0; held_valid = 1'b0; seen_done = 1'b0;
    @(negedge r_clk);
    initial_address = base;
    output_featuremapsize = n;
    fill_done = (fill_delay == 0);
    enable = 1'b1;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge r_clk);
      if (cyc == fill_delay) fill_done = 1'b1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (read_enable) begin
        if (first_re < 0) first_re = cyc;
        addrs.push_back(r_address);
        if (!fill_done) nofill_err++;
      end
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (held_valid && (!out_valid || out_data !== held)) stall_err++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        held_valid = 1'b0;
      end else if (out_valid) begin
        held_valid = 1'b1;
        held = out_data;
      end else begin
        held_valid = 1'b0;
      end
      if (done) begin
        seen_done = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, 32'(seen_done), 32'd1);
    chk({tag, "_count"}, 32'(got.size()), 32'(total));
    chk({tag, "_nreads"}, 32'(addrs.size()), 32'(total));
    for (int i = 0; i < got.size() && i < total; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(got[i]),
          32'(ref_word(mem[(int'(base) + i) % DEPTH])));
    end
    for (int i = 0; i < addrs.size(); i++) begin
      if (int'(addrs[i]) != (int'(base) + i) % DEPTH) addr_err++;
    end
    chk({tag, "_addr"}, 32'(addr_err), 32'd0);
    chk({tag, "_stall_stable"}, 32'(stall_err), 32'd0);
    chk({tag, "_read_wo_fill"}, 32'(nofill_err), 32'd0);
    if (total > 0) begin
      chk({tag, "_first_read"}, 32'(first_re), 32'(fill_delay + 1));
      chk({tag, "_first_valid"}, 32'(first_ov), 32'(first_re + 2));
      if (mode == 0) chk({tag, "_no_bubble"}, 32'(last_x - first_x + 1), 32'(total));
    end else begin
      chk({tag, "_n0_latency"}, 32'(cyc <= 2), 32'd1);
    end
    enable = 1'b0;
    fill_done = 1'b0;
    @(negedge r_clk);
    #1;
    chk({tag, "_ack_done"}, 32'(done), 32'd0);
    chk({tag, "_ack_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int xfers;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);

    repeat (3) @(negedge r_clk);
    #1;
    chk("rst_r_address", 32'(r_address), 32'd0);
    chk("rst_read_enable", 32'(read_enable), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;

    run_drain("n3", 14'h0010, 16'd3, 0, 0);
    run_drain("wrap", 14'h3FFE, 16'd2, 0, 0);
    run_drain("toggle", 14'($urandom), 16'd4, 1, 0);
    run_drain("nofill", 14'h0200, 16'd2, 0, 10);
    run_drain("n0", 14'h0300, 16'd0, 0, 0);

    mem[14'h0100] = 16'hFFFB;
    mem[14'h0101] = 16'h0007;
    mem[14'h0102] = 16'h8000;
    mem[14'h0103] = 16'h0003;
    run_drain("relu", 14'h0100, 16'd2, 0, 0);

    // Abort after five words.
    @(negedge r_clk);
    initial_address = 14'h0020;
    output_featuremapsize = 16'd3;
    fill_done = 1'b1;
    out_ready = 1'b1;
    enable = 1'b1;
    xfers = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge r_clk);
      #1;
      if (out_valid && out_ready) xfers++;
      if (xfers == 5) break;
    end
    chk("abort_reached", 32'(xfers), 32'd5);
    enable = 1'b0;
    @(negedge r_clk);
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_read_enable", 32'(read_enable), 32'd0);
    chk("abort_r_address", 32'(r_address), 32'd0);
    chk("abort_done", 32'(done), 32'd0);

    // Reset mid-stream.
    enable = 1'b1;
    xfers = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge r_clk);
      #1;
      if (out_valid && out_ready) xfers++;
      if (xfers == 3) break;
    end
    chk("rst_mid_reached", 32'(xfers), 32'd3);
    reset = 1'b0;
    @(negedge r_clk);
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_out_data", 32'(out_data), 32'd0);
    chk("rst_mid_r_address", 32'(r_address), 32'd0);
    chk("rst_mid_read_enable", 32'(read_enable), 32'd0);
    enable = 1'b0;
    fill_done = 1'b0;
    @(negedge r_clk);
    reset = 1'b1;
    run_drain("restart", 14'h0020, 16'd3, 0, 0);

    for (int k = 0; k < 6; k++) begin
      run_drain($sformatf("rand%0d", k), 14'($urandom), 16'($urandom_range(1, 6)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
